// File: rtl/lock_access_ctrl_if.sv
// Write-request bus between the requesters and the lock access controller.
// Each requester holds req until it sees its own ack or err pulse.
interface lock_access_ctrl_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    err;

    modport master (output req, output wdata, input ack, input err);
    modport slave  (input req, input wdata, output ack, output err);
endinterface

// File: rtl/lock_access_ctrl.sv
// Round-robin write arbiter gated by a sticky lock, plus the two-word debug
// unlock sequence with inter-word timeout and failed-attempt lockout.
module lock_access_ctrl #(
    parameter int          NREQ     = 4,
    parameter logic [15:0] KEY0     = 16'hA5C3,
    parameter logic [15:0] KEY1     = 16'h3C5A,
    parameter int          TIMEOUT  = 16,
    parameter int          MAX_FAIL = 3
) (
    input  logic                clk,
    input  logic                resetn,
    lock_access_ctrl_if.slave   wr,
    input  logic                lock_set,
    input  logic                key_valid,
    input  logic [15:0]         key_data,
    input  logic                debug_relock,
    output logic                reg_write,
    output logic [15:0]         reg_wdata,
    output logic                lock_status,
    output logic                debug_unlocked,
    output logic                lockout
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int FW = $clog2(MAX_FAIL + 1);

    typedef enum logic [0:0] {IDLE, HOLD} arb_state_t;
    typedef enum logic [1:0] {K_IDLE, K_GOT0, K_UNLOCKED, K_LOCKOUT} key_state_t;

    arb_state_t      arb_reg, arb_next;
    key_state_t      key_reg, key_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [NREQ-1:0] ack_reg, ack_next;
    logic [NREQ-1:0] err_reg, err_next;
    logic            reg_write_reg, reg_write_next;
    logic [15:0]     reg_wdata_reg, reg_wdata_next;
    logic            lock_reg, lock_next;
    logic            du_reg, du_next;
    logic            lockout_reg, lockout_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [FW-1:0]   fail_reg, fail_next;

    logic [15:0]     wdata_slice [NREQ];
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic            found;
    logic            allowed;
    logic            fail_event;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign wdata_slice[gi] = wr.wdata[16*gi +: 16];
    end

    // Uses the registered lock/debug flags, so a lock_set on the grant edge
    // does not block that grant.
    assign allowed = ~lock_reg | du_reg;

    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_reg) + k) % NREQ);
            if (!found && wr.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        arb_next       = arb_reg;
        ptr_next       = ptr_reg;
        ack_next       = '0;
        err_next       = '0;
        reg_write_next = 1'b0;
        reg_wdata_next = reg_wdata_reg;
        case (arb_reg)
            IDLE: begin
                if (found) begin
                    if (allowed) begin
                        ack_next[win]  = 1'b1;
                        reg_write_next = 1'b1;
                        reg_wdata_next = wdata_slice[win];
                    end else begin
                        err_next[win]  = 1'b1;
                    end
                    ptr_next = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
                    arb_next = HOLD;
                end
            end
            HOLD:    arb_next = IDLE;
            default: arb_next = IDLE;
        endcase
    end

    assign lock_next = lock_reg | lock_set;

    always_comb begin
        key_next     = key_reg;
        timer_next   = timer_reg;
        fail_next    = fail_reg;
        du_next      = du_reg;
        lockout_next = lockout_reg;
        fail_event   = 1'b0;
        case (key_reg)
            K_IDLE: begin
                if (key_valid) begin
                    if (key_data == KEY0) begin
                        key_next   = K_GOT0;
                        timer_next = '0;
                    end else begin
                        fail_event = 1'b1;
                    end
                end
            end
            K_GOT0: begin
                if (key_valid) begin
                    if (key_data == KEY1) begin
                        fail_next = '0;
                        du_next   = ~debug_relock;
                        key_next  = debug_relock ? K_IDLE : K_UNLOCKED;
                    end else begin
                        fail_event = 1'b1;
                    end
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    fail_event = 1'b1;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            K_UNLOCKED: begin
                if (debug_relock) begin
                    du_next  = 1'b0;
                    key_next = K_IDLE;
                end
            end
            K_LOCKOUT: du_next = 1'b0;
            default:   key_next = K_IDLE;
        endcase
        if (fail_event) begin
            fail_next = fail_reg + FW'(1);
            if (fail_next == FW'(MAX_FAIL)) begin
                lockout_next = 1'b1;
                key_next     = K_LOCKOUT;
            end else begin
                key_next     = K_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            arb_reg       <= IDLE;
            key_reg       <= K_IDLE;
            ptr_reg       <= '0;
            ack_reg       <= '0;
            err_reg       <= '0;
            reg_write_reg <= 1'b0;
            reg_wdata_reg <= '0;
            lock_reg      <= 1'b0;
            du_reg        <= 1'b0;
            lockout_reg   <= 1'b0;
            timer_reg     <= '0;
            fail_reg      <= '0;
        end else begin
            arb_reg       <= arb_next;
            key_reg       <= key_next;
            ptr_reg       <= ptr_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            reg_write_reg <= reg_write_next;
            reg_wdata_reg <= reg_wdata_next;
            lock_reg      <= lock_next;
            du_reg        <= du_next;
            lockout_reg   <= lockout_next;
            timer_reg     <= timer_next;
            fail_reg      <= fail_next;
        end
    end

    assign wr.ack         = ack_reg;
    assign wr.err         = err_reg;
    assign reg_write      = reg_write_reg;
    assign reg_wdata      = reg_wdata_reg;
    assign lock_status    = lock_reg;
    assign debug_unlocked = du_reg;
    assign lockout        = lockout_reg;
endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed bench for lock_access_ctrl: writes, round robin, lock, debug
// unlock, timeout/lockout and reset during a handshake.
module tb_lock_access_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        lock_set, key_valid, debug_relock;
    logic [15:0] key_data;
    logic        reg_write, lock_status, debug_unlocked, lockout;
    logic [15:0] reg_wdata;
    int checks = 0;
    int errors = 0;

    lock_access_ctrl_if #(.NREQ(4)) bus ();

    lock_access_ctrl #(.NREQ(4)) dut (
        .clk(clk), .resetn(resetn), .wr(bus.slave), .lock_set(lock_set),
        .key_valid(key_valid), .key_data(key_data), .debug_relock(debug_relock),
        .reg_write(reg_write), .reg_wdata(reg_wdata), .lock_status(lock_status),
        .debug_unlocked(debug_unlocked), .lockout(lockout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [15:0] word);
        key_valid = 1'b1;
        key_data  = word;
        tick();
        key_valid = 1'b0;
        key_data  = 16'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL rst_ack got %b exp 0000", bus.ack); end
        checks++; if (bus.err !== 4'b0) begin errors++; $display("FAIL rst_err got %b exp 0000", bus.err); end
        checks++; if (reg_write !== 1'b0 || reg_wdata !== 16'h0) begin errors++; $display("FAIL rst_reg got %b/%h exp 0/0000", reg_write, reg_wdata); end
        checks++; if ({lock_status, debug_unlocked, lockout} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {lock_status, debug_unlocked, lockout}); end
        resetn = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_unlocked_write();
        bus.req = 4'b0001;
        bus.wdata = {16'h0, 16'h0, 16'h0, 16'h1234};
        tick();
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL unl_ack got %b exp 0001", bus.ack); end
        checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL unl_err got %b exp 0000", bus.err); end
        checks++; if (reg_write !== 1'b1 || reg_wdata !== 16'h1234) begin errors++; $display("FAIL unl_data got %b/%h exp 1/1234", reg_write, reg_wdata); end
        bus.req = 4'b0;
        tick();
        checks++; if (bus.ack !== 4'b0 || reg_write !== 1'b0) begin errors++; $display("FAIL unl_hold got %b/%b exp 0000/0", bus.ack, reg_write); end
        $display("txn unlocked write req0 data %h", reg_wdata);
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ack;
        logic [15:0] exp_data;
        resetn = 1'b0; tick(); resetn = 1'b1;
        bus.wdata = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_ack  = 4'b0001 << (g % 4);
            exp_data = 16'h1000 + 16'(g % 4);
            tick();
            checks++; if (bus.ack !== exp_ack || reg_wdata !== exp_data) begin errors++; $display("FAIL rr_grant%0d got %b/%h exp %b/%h", g, bus.ack, reg_wdata, exp_ack, exp_data); end
            $display("txn rr grant %0d ack %b data %h", g, bus.ack, reg_wdata);
            if (g == 4) bus.req = 4'b0;
            tick();
            checks++; if (bus.ack !== 4'b0 || reg_write !== 1'b0) begin errors++; $display("FAIL rr_hold%0d got %b/%b exp 0000/0", g, bus.ack, reg_write); end
        end
    endtask

    task automatic test_lock();
        // lock_set on the grant edge: that write is still accepted
        lock_set = 1'b1;
        bus.req = 4'b0001;
        bus.wdata = {16'h0, 16'h0, 16'hBEEF, 16'h2222};
        tick();
        lock_set = 1'b0;
        bus.req = 4'b0;
        checks++; if (bus.ack !== 4'b0001 || reg_wdata !== 16'h2222) begin errors++; $display("FAIL lock_same_edge got %b/%h exp 0001/2222", bus.ack, reg_wdata); end
        checks++; if (lock_status !== 1'b1) begin errors++; $display("FAIL lock_status got %b exp 1", lock_status); end
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0;
        checks++; if (bus.err !== 4'b0010 || bus.ack !== 4'b0) begin errors++; $display("FAIL lock_err got %b/%b exp 0010/0000", bus.err, bus.ack); end
        checks++; if (reg_write !== 1'b0 || reg_wdata !== 16'h2222) begin errors++; $display("FAIL lock_reg got %b/%h exp 0/2222", reg_write, reg_wdata); end
        $display("txn locked write req1 err %b", bus.err);
        tick();
        checks++; if (bus.err !== 4'b0) begin errors++; $display("FAIL lock_hold got %b exp 0000", bus.err); end
    endtask

    task automatic test_debug_unlock();
        send_key(16'hA5C3);
        tick(); tick();
        send_key(16'h3C5A);
        checks++; if (debug_unlocked !== 1'b1) begin errors++; $display("FAIL dbg_unlocked got %b exp 1", debug_unlocked); end
        bus.req = 4'b0100;
        bus.wdata = {16'h0, 16'h5678, 16'h0, 16'h0};
        tick();
        bus.req = 4'b0;
        checks++; if (bus.ack !== 4'b0100 || reg_write !== 1'b1 || reg_wdata !== 16'h5678) begin errors++; $display("FAIL dbg_write got %b/%b/%h exp 0100/1/5678", bus.ack, reg_write, reg_wdata); end
        $display("txn debug write req2 data %h", reg_wdata);
        tick();
        debug_relock = 1'b1; tick(); debug_relock = 1'b0;
        checks++; if (debug_unlocked !== 1'b0) begin errors++; $display("FAIL dbg_relock got %b exp 0", debug_unlocked); end
        bus.req = 4'b1000;
        tick();
        bus.req = 4'b0;
        checks++; if (bus.err !== 4'b1000 || reg_write !== 1'b0) begin errors++; $display("FAIL dbg_relock_err got %b/%b exp 1000/0", bus.err, reg_write); end
        tick();
        // relock on the same edge as KEY1 wins
        send_key(16'hA5C3);
        debug_relock = 1'b1;
        send_key(16'h3C5A);
        debug_relock = 1'b0;
        checks++; if (debug_unlocked !== 1'b0) begin errors++; $display("FAIL dbg_relock_race got %b exp 0", debug_unlocked); end
    endtask

    task automatic test_timeout_lockout();
        // 15 idle cycles is still inside the window
        send_key(16'hA5C3);
        repeat (15) tick();
        send_key(16'h3C5A);
        checks++; if (debug_unlocked !== 1'b1) begin errors++; $display("FAIL to_edge_ok got %b exp 1", debug_unlocked); end
        debug_relock = 1'b1; tick(); debug_relock = 1'b0;
        // 16 idle cycles times out: first failure
        send_key(16'hA5C3);
        repeat (16) tick();
        checks++; if (debug_unlocked !== 1'b0 || lockout !== 1'b0) begin errors++; $display("FAIL to_fail1 got %b/%b exp 0/0", debug_unlocked, lockout); end
        send_key(16'h1111);
        checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL to_fail2 got %b exp 0", lockout); end
        send_key(16'h2222);
        checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL to_lockout got %b exp 1", lockout); end
        send_key(16'hA5C3);
        send_key(16'h3C5A);
        tick();
        checks++; if (debug_unlocked !== 1'b0 || lockout !== 1'b1) begin errors++; $display("FAIL to_locked_keys got %b/%b exp 0/1", debug_unlocked, lockout); end
        $display("txn lockout reached lockout=%b", lockout);
    endtask

    task automatic test_reset_mid_hold();
        bus.req = 4'b0001;
        bus.wdata = {16'h0, 16'h0, 16'h0, 16'hABCD};
        tick();
        checks++; if (bus.err !== 4'b0001) begin errors++; $display("FAIL rmh_err got %b exp 0001", bus.err); end
        resetn = 1'b0;
        bus.req = 4'b0;
        tick();
        resetn = 1'b1;
        checks++; if ({bus.ack, bus.err, reg_write, lock_status, debug_unlocked, lockout} !== 12'h0 || reg_wdata !== 16'h0) begin errors++; $display("FAIL rmh_outputs got %b%b%b%b%b%b/%h exp all 0", bus.ack, bus.err, reg_write, lock_status, debug_unlocked, lockout, reg_wdata); end
        tick();
        checks++; if (bus.ack !== 4'b0 || bus.err !== 4'b0 || reg_write !== 1'b0) begin errors++; $display("FAIL rmh_quiet got %b/%b/%b exp 0", bus.ack, bus.err, reg_write); end
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0;
        checks++; if (bus.ack !== 4'b0001 || reg_wdata !== 16'hABCD) begin errors++; $display("FAIL rmh_first got %b/%h exp 0001/abcd", bus.ack, reg_wdata); end
        $display("txn post-reset write ack %b data %h", bus.ack, reg_wdata);
        tick();
    endtask

    initial begin
        resetn = 1'b0; lock_set = 1'b0; key_valid = 1'b0; key_data = 16'h0;
        debug_relock = 1'b0; bus.req = 4'b0; bus.wdata = '0;
        test_reset();
        test_unlocked_write();
        test_round_robin();
        test_lock();
        test_debug_unlock();
        test_timeout_lockout();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lock_access_ctrl.md
Name: lock_access_ctrl

Overview:
- Front-end controller for a bank of lockable 16-bit configuration registers.
- Arbitrates write requests from NREQ requesters using round-robin and issues a single write strobe to the register datapath.
- Owns the sticky lock state and the debug-unlock key sequence, including failed-attempt lockout.
- Drives the lock_status and debug_unlocked qualifiers consumed by the downstream locked registers.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- KEY0, 16'hA5C3, first debug-unlock key word.
- KEY1, 16'h3C5A, second debug-unlock key word.
- TIMEOUT, 16, maximum cycles allowed between KEY0 and KEY1.
- MAX_FAIL, 3, failed unlock attempts before permanent lockout.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester write request; held high until ack or err is seen.
- wdata  in  16*NREQ  per-requester write data; slice i is bits [16*i+15:16*i].
- ack  out  NREQ  one-cycle pulse: write accepted.
- err  out  NREQ  one-cycle pulse: write rejected because the register is locked.
- lock_set  in  1  pulse; sets the sticky lock.
- key_valid  in  1  debug key word strobe.
- key_data  in  16  debug key word.
- debug_relock  in  1  pulse; clears debug_unlocked.
- reg_write  out  1  write strobe to the register datapath.
- reg_wdata  out  16  write data to the register datapath.
- lock_status  out  1  sticky lock flag.
- debug_unlocked  out  1  debug override flag.
- lockout  out  1  key interface permanently disabled.

Behaviour:
- Clock and reset: clk, with resetn synchronous and active-low.
- Reset values: ack=0, err=0, reg_write=0, reg_wdata=0, lock_status=0, debug_unlocked=0, lockout=0. The round-robin pointer resets to 0, the fail counter to 0, the arbiter FSM to IDLE and the key FSM to K_IDLE.
- Reset applied mid-operation aborts any pending handshake and key sequence. No outputs pulse on the following cycle.
- All outputs are registered.

Arbiter FSM (IDLE, HOLD):
- IDLE with req != 0:
  - Winner is the first asserted req at or after the pointer, searching upward with wrap.
  - allowed = ~lock_status | debug_unlocked, using the current register values.
  - If allowed: ack[w]<=1, reg_write<=1, reg_wdata<=wdata[w].
  - If not allowed: err[w]<=1, reg_write<=0, and reg_wdata is unchanged.
  - Pointer <= (w+1) mod NREQ. Go to HOLD.
- HOLD: ack, err and reg_write are cleared, and req is ignored. Return to IDLE.
- Throughput is at most one grant every 2 cycles. Latency from req sampled to ack/reg_write visible is 1 cycle.
- Requesters deassert req before the HOLD edge. A req still high in IDLE counts as a new request.
- The pointer advances only on a grant, whether ack or err.

Lock:
- lock_set sets lock_status at the next edge. Only reset clears it.
- A grant decided at the same edge as lock_set uses the pre-edge lock_status, so that write is still accepted.

Key FSM (K_IDLE, K_GOT0, K_UNLOCKED, K_LOCKOUT):
- K_IDLE, key_valid:
  - key_data==KEY0: go to K_GOT0 and load timer=0.
  - Otherwise: fail.
- K_GOT0: timer increments each cycle without key_valid.
  - key_valid with key_data==KEY1: debug_unlocked<=1, fail_cnt<=0, go to K_UNLOCKED.
  - key_valid with a wrong word: fail.
  - timer reaching TIMEOUT-1 with no key_valid: fail.
- Fail: fail_cnt+1.
  - If the new count equals MAX_FAIL: lockout<=1, go to K_LOCKOUT.
  - Otherwise go to K_IDLE.
- K_UNLOCKED: keys are ignored. debug_relock clears debug_unlocked and returns to K_IDLE.
- K_LOCKOUT: all keys are ignored and debug_unlocked stays 0. Exit is by reset only.
- debug_relock on the same edge as KEY1 success: relock wins, debug_unlocked stays 0, and the FSM goes to K_IDLE with fail_cnt cleared.
- The key FSM runs regardless of lock_status.

Test Plan:
- Unlocked writes, req=4'b0001 with wdata0=16'h1234: ack[0] pulses 1 cycle after req, with reg_write=1 and reg_wdata=16'h1234 in the same cycle; no err.
- Round-robin fairness, req=4'b1111 held continuously: grants go 0,1,2,3,0 on every second cycle, with exactly one ack bit per grant.
- Lock, lock_set pulse then req=4'b0010: lock_status=1, err[1] pulses, reg_write stays 0, and reg_wdata keeps its old value.
- Debug unlock:
  - With locked state, send key A5C3 then 3C5A within 5 cycles: debug_unlocked=1, and the next write is acked with reg_write=1.
  - debug_relock then restores the err response.
- Timeout and lockout:
  - KEY0 followed by 16 idle cycles gives fail_cnt=1.
  - Two wrong KEY0 words bring fail_cnt to 3: lockout=1, and a correct sequence afterwards leaves debug_unlocked=0.
- Reset mid-HOLD with lockout=1 and lock_status=1: on the next cycle all outputs are 0, and the first request afterwards is acked.
